// File: rtl/izz_pkg.sv
// Shared constants for the inverse zigzag stream: zigzag-to-raster map and block geometry.
package izz_pkg;

  localparam int BLK_COEFS = 64;
  localparam int ROW_LEN   = 8;

  // Entry i is the raster address (row*8 + col) of the i-th coefficient in zigzag order.
  localparam logic [5:0] ZZ2RASTER [0:63] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  function automatic int beats(input int lanes);
    return BLK_COEFS / lanes;
  endfunction

endpackage

// File: rtl/inverse_zigzag_stream_if.sv
// Valid/ready stream bundle: zigzag coefficient beats in, raster rows (or columns) out.
interface inverse_zigzag_stream_if #(
  parameter int DATA_W   = 8,
  parameter int IN_LANES = 1
);
  logic                         in_valid;
  logic                         in_ready;
  logic [IN_LANES*DATA_W-1:0]   in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [8*DATA_W-1:0]          out_data;
  logic [2:0]                   out_row;
  logic                         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_row, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_row, out_last
  );
endinterface

// File: rtl/izz_bank.sv
// One 64-coefficient raster bank: IN_LANES scattered writes, 8-wide combinational read.
// IZZ_COL_ORDER_EN defined: the read port returns a column instead of a row.
module izz_bank
  import izz_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int IN_LANES = 1
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [5:0]                  waddr [IN_LANES],
  input  logic [IN_LANES*DATA_W-1:0]  wdata,
  input  logic [2:0]                  rsel,
  output logic [ROW_LEN*DATA_W-1:0]   rdata
);

  logic [DATA_W-1:0] mem [BLK_COEFS];

  // Lane 0 sits in the MSBs and carries the lowest zigzag index of the beat.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < IN_LANES; k++) begin
        mem[waddr[k]] <= wdata[(IN_LANES-1-k)*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int c = 0; c < ROW_LEN; c++) begin
`ifdef IZZ_COL_ORDER_EN
      rdata[(ROW_LEN-1-c)*DATA_W +: DATA_W] = mem[{3'(c), rsel}];
`else
      rdata[(ROW_LEN-1-c)*DATA_W +: DATA_W] = mem[{rsel, 3'(c)}];
`endif
    end
  end

endmodule

// File: rtl/inverse_zigzag_stream.sv
// Double-buffered streaming inverse zigzag: zigzag beats in, one 8-coefficient row per beat out.
// IZZ_COL_ORDER_EN (optional macro, read in izz_bank) switches output beats to columns.
module inverse_zigzag_stream
  import izz_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int IN_LANES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  inverse_zigzag_stream_if.slave  zs
);

  localparam int         BEATS     = beats(IN_LANES);
  localparam logic [5:0] LAST_BEAT = 6'(BEATS - 1);

  logic [1:0]              full;
  logic                    wr_sel;
  logic                    rd_sel;
  logic [5:0]              wr_cnt;
  logic [2:0]              rd_row;
  logic                    accept;
  logic                    take;
  logic                    wr_last;
  logic                    rd_last;
  logic [5:0]              waddr [IN_LANES];
  logic [8*DATA_W-1:0]     rdata [2];

  assign zs.in_ready  = !rst && !full[wr_sel];
  assign zs.out_valid = !rst && full[rd_sel];
  assign accept       = zs.in_valid && zs.in_ready;
  assign take         = zs.out_valid && zs.out_ready;
  assign wr_last      = (wr_cnt == LAST_BEAT);
  assign rd_last      = (rd_row == 3'd7);

  always_comb begin
    for (int k = 0; k < IN_LANES; k++) begin
      waddr[k] = ZZ2RASTER[6'(int'(wr_cnt) * IN_LANES + k)];
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    izz_bank #(
      .DATA_W   (DATA_W),
      .IN_LANES (IN_LANES)
    ) u_bank (
      .clk   (clk),
      .we    (accept && (wr_sel == 1'(b))),
      .waddr (waddr),
      .wdata (zs.in_data),
      .rsel  (rd_row),
      .rdata (rdata[b])
    );
  end

  assign zs.out_data = rdata[rd_sel];
  assign zs.out_row  = rd_row;
  assign zs.out_last = rd_last;

  // Writer and reader never finish on the same bank in one cycle, so both full-bit updates can land.
  always_ff @(posedge clk) begin
    if (rst) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= 6'd0;
      rd_row <= 3'd0;
    end else begin
      if (accept) begin
        if (wr_last) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= !wr_sel;
          wr_cnt       <= 6'd0;
        end else begin
          wr_cnt <= wr_cnt + 6'd1;
        end
      end
      if (take) begin
        if (rd_last) begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= !rd_sel;
          rd_row       <= 3'd0;
        end else begin
          rd_row <= rd_row + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inverse_zigzag_stream.sv
// Randomized bench for inverse_zigzag_stream with IN_LANES=1 and IN_LANES=4 instances.
module tb_inverse_zigzag_stream;

  typedef logic [7:0] blk_t [64];
  typedef struct packed {
    logic [63:0] d;
    logic [2:0]  r;
  } exp_t;

`ifdef IZZ_COL_ORDER_EN
  localparam logic [63:0] BEAT0_IDX = 64'h00020309_0A141523;
`else
  localparam logic [63:0] BEAT0_IDX = 64'h00010506_0E0F1B1C;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inverse_zigzag_stream_if #(.DATA_W(8), .IN_LANES(1)) if1 ();
  inverse_zigzag_stream_if #(.DATA_W(8), .IN_LANES(4)) if4 ();

  inverse_zigzag_stream #(.DATA_W(8), .IN_LANES(1)) u_dut1 (.clk(clk), .rst(rst), .zs(if1.slave));
  inverse_zigzag_stream #(.DATA_W(8), .IN_LANES(4)) u_dut4 (.clk(clk), .rst(rst), .zs(if4.slave));

  exp_t eq1[$];
  exp_t eq4[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   n_rows1 = 0;
  int   n_rows4 = 0;
  int   rdy_mode1 = 0;
  int   rdy_mode4 = 0;
  int   zz_pos [64];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Zigzag order from first principles: walk anti-diagonals, alternating direction.
  task automatic build_zz();
    int i = 0;
    for (int s = 0; s < 15; s++) begin
      int lo = (s > 7) ? s - 7 : 0;
      int hi = (s < 7) ? s : 7;
      if (s % 2 == 0) begin
        for (int r = hi; r >= lo; r--) begin zz_pos[i] = r * 8 + (s - r); i++; end
      end else begin
        for (int r = lo; r <= hi; r++) begin zz_pos[i] = r * 8 + (s - r); i++; end
      end
    end
  endtask

  task automatic push_expect(input int sel, input blk_t v);
    logic [7:0] ras [64];
    exp_t e;
    for (int i = 0; i < 64; i++) ras[zz_pos[i]] = v[i];
    for (int j = 0; j < 8; j++) begin
      e.d = '0;
      for (int c = 0; c < 8; c++) begin
`ifdef IZZ_COL_ORDER_EN
        e.d[(7-c)*8 +: 8] = ras[c*8 + j];
`else
        e.d[(7-c)*8 +: 8] = ras[j*8 + c];
`endif
      end
      e.r = 3'(j);
      if (sel == 4) eq4.push_back(e); else eq1.push_back(e);
    end
  endtask

  function automatic int qsize(input int sel);
    return (sel == 4) ? eq4.size() : eq1.size();
  endfunction

  function automatic logic get_rdy(input int sel);
    return (sel == 4) ? if4.in_ready : if1.in_ready;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [31:0] d);
    if (sel == 4) begin if4.in_valid = v; if4.in_data = d; end
    else begin if1.in_valid = v; if1.in_data = d[7:0]; end
  endtask

  // Entered and left at posedge+1; sel is the lane count of the target instance.
  task automatic send_beats(input int sel, input blk_t v, input int nbeats, input int vprob,
                            output int stalls);
    int b = 0;
    int cyc = 0;
    logic valid;
    logic r;
    logic [31:0] d;
    stalls = 0;
    while (b < nbeats && cyc < 5000) begin
      valid = ($urandom_range(99) < vprob);
      d = '0;
      for (int k = 0; k < sel; k++) d[(sel-1-k)*8 +: 8] = v[b*sel + k];
      drive(sel, valid, d);
      @(negedge clk);
      r = get_rdy(sel);
      if (valid && !r) stalls++;
      @(posedge clk);
      cyc++;
      if (valid && r) begin
        if (b == 64/sel - 1) push_expect(sel, v);
        b++;
      end
      #1;
    end
    drive(sel, 1'b0, '0);
    if (cyc >= 5000) chk("send_timeout", 64'(b), 64'(nbeats));
  endtask

  task automatic drain(input int sel);
    int c = 0;
    while (qsize(sel) != 0 && c < 3000) begin @(posedge clk); c++; end
    @(posedge clk); #1;
    chk("drain_left", 64'(qsize(sel)), 64'd0);
    chk("drain_idle", (sel == 4) ? if4.out_valid : if1.out_valid, 64'd0);
  endtask

  function automatic blk_t rnd_blk();
    blk_t v;
    for (int i = 0; i < 64; i++) v[i] = 8'($urandom);
    return v;
  endfunction

  // Output ready generators: 0 always, 1 held low, 2 random, 3 toggling.
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode1)
      0: if1.out_ready = 1'b1;
      1: if1.out_ready = 1'b0;
      2: if1.out_ready = 1'($urandom_range(1));
      default: if1.out_ready = ~if1.out_ready;
    endcase
    case (rdy_mode4)
      0: if4.out_ready = 1'b1;
      1: if4.out_ready = 1'b0;
      2: if4.out_ready = 1'($urandom_range(1));
      default: if4.out_ready = ~if4.out_ready;
    endcase
  end

  initial begin : mon1
    logic hold = 1'b0;
    logic [63:0] hd;
    logic [2:0] hr;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) hold = 1'b0;
      else if (if1.out_valid) begin
        if (hold) begin
          chk("hold_data1", if1.out_data, hd);
          chk("hold_row1", 64'(if1.out_row), 64'(hr));
        end
        if (if1.out_ready) begin
          n_rows1++;
          if (eq1.size() == 0) chk("extra_row1", 64'(if1.out_valid), 64'd0);
          else begin
            e = eq1.pop_front();
            chk("data1", if1.out_data, e.d);
            chk("row1", 64'(if1.out_row), 64'(e.r));
            chk("last1", 64'(if1.out_last), 64'(e.r == 3'd7));
          end
        end
        hold = !if1.out_ready; hd = if1.out_data; hr = if1.out_row;
      end else hold = 1'b0;
    end
  end

  initial begin : mon4
    logic hold = 1'b0;
    logic [63:0] hd;
    logic [2:0] hr;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) hold = 1'b0;
      else if (if4.out_valid) begin
        if (hold) begin
          chk("hold_data4", if4.out_data, hd);
          chk("hold_row4", 64'(if4.out_row), 64'(hr));
        end
        if (if4.out_ready) begin
          n_rows4++;
          if (eq4.size() == 0) chk("extra_row4", 64'(if4.out_valid), 64'd0);
          else begin
            e = eq4.pop_front();
            chk("data4", if4.out_data, e.d);
            chk("row4", 64'(if4.out_row), 64'(e.r));
            chk("last4", 64'(if4.out_last), 64'(e.r == 3'd7));
          end
        end
        hold = !if4.out_ready; hd = if4.out_data; hr = if4.out_row;
      end else hold = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    blk_t idx;
    int st, st2, base;
    logic seen7;
    build_zz();
    for (int i = 0; i < 64; i++) idx[i] = 8'(i);
    rst = 1'b1;
    drive(1, 1'b0, '0);
    drive(4, 1'b0, '0);
    if1.out_ready = 1'b1;
    if4.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready1", 64'(if1.in_ready), 64'd0);
    chk("rst_out_valid1", 64'(if1.out_valid), 64'd0);
    chk("rst_in_ready4", 64'(if4.in_ready), 64'd0);
    chk("rst_out_valid4", 64'(if4.out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready1", 64'(if1.in_ready), 64'd1);
    chk("post_rst_ready4", 64'(if4.in_ready), 64'd1);
    @(posedge clk); #1;

    // Index-valued block: row 0 must appear the cycle after the final beat.
    send_beats(1, idx, 64, 100, st);
    @(negedge clk);
    chk("t1_latency_valid", 64'(if1.out_valid), 64'd1);
    chk("t1_beat0", if1.out_data, BEAT0_IDX);
    chk("t1_beat0_row", 64'(if1.out_row), 64'd0);
    @(posedge clk); #1;
    drain(1);

    // Three blocks back-to-back with full-rate input and output.
    base = n_rows1;
    st2 = 0;
    for (int n = 0; n < 3; n++) begin
      send_beats(1, rnd_blk(), 64, 100, st);
      st2 += st;
    end
    chk("t2_stalls", 64'(st2), 64'd0);
    drain(1);
    chk("t2_rows", 64'(n_rows1 - base), 64'd24);

    // Output stalled: two blocks fill both banks, the third beat is refused.
    rdy_mode1 = 1;
    @(posedge clk); #1;
    send_beats(1, idx, 64, 100, st);
    send_beats(1, rnd_blk(), 64, 100, st2);
    chk("t3_stalls", 64'(st + st2), 64'd0);
    drive(1, 1'b1, 32'hA5);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t3_refuse", 64'(if1.in_ready), 64'd0);
      chk("t3_row0_hold", if1.out_data, BEAT0_IDX);
      @(posedge clk); #1;
    end
    drive(1, 1'b0, '0);
    rdy_mode1 = 0;
    seen7 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (seen7) begin
        chk("t3_ready_rise", 64'(if1.in_ready), 64'd1);
        break;
      end
      chk("t3_ready_low", 64'(if1.in_ready), 64'd0);
      if (if1.out_valid && if1.out_ready && if1.out_last) seen7 = 1'b1;
      @(posedge clk);
    end
    @(posedge clk); #1;
    chk("t3_row7_seen", 64'(seen7), 64'd1);
    send_beats(1, rnd_blk(), 64, 100, st);
    drain(1);

    // Reset after a partial block; only the following block may come out.
    rdy_mode1 = 2;
    send_beats(1, rnd_blk(), 20, 100, st);
    rst = 1'b1;
    @(negedge clk);
    chk("t4_rst_in_ready", 64'(if1.in_ready), 64'd0);
    chk("t4_rst_out_valid", 64'(if1.out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    eq1.delete();
    base = n_rows1;
    send_beats(1, rnd_blk(), 64, 100, st);
    drain(1);
    chk("t4_rows", 64'(n_rows1 - base), 64'd8);

    // Random traffic on both ends.
    for (int n = 0; n < 4; n++) send_beats(1, rnd_blk(), 64, 70, st);
    drain(1);

    // Four lanes per beat, output ready toggling.
    rdy_mode4 = 3;
    base = n_rows4;
    send_beats(4, idx, 16, 100, st);
    drain(4);
    chk("t5_rows", 64'(n_rows4 - base), 64'd8);
    rdy_mode4 = 2;
    for (int n = 0; n < 3; n++) send_beats(4, rnd_blk(), 16, 60, st);
    drain(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
